// File: rtl/fir_coeff_sequencer_pkg.sv
// Shared definitions for the FIR coefficient sequencer: default sizes,
// reset coefficient image, FSM state encoding and a width helper.
package fir_coeff_sequencer_pkg;

  localparam int DATA_W_DEF   = 6;
  localparam int NUM_TAPS_DEF = 3;

  // Reset image of the coefficient bank, tap0 in the MSBs: 7, -5, 27.
  localparam logic [NUM_TAPS_DEF*DATA_W_DEF-1:0] COEF_INIT_DEF = {6'd7, 6'h3B, 6'd27};

  // STREAM: samples flow to the FIR.
  // LOAD:   snapshot is shifted out with s_set_coeffs high.
  // GUARD:  one idle cycle separating a load from whatever follows.
  typedef enum logic [1:0] {
    ST_STREAM = 2'd0,
    ST_LOAD   = 2'd1,
    ST_GUARD  = 2'd2
  } seq_state_t;

  // Index width for n entries, never narrower than one bit.
  function automatic int tap_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// Host-writable coefficient bank plus the snapshot shift register that the
// sequencer drains during a load. The snapshot sees a same-cycle write.
module fir_coeff_bank
  import fir_coeff_sequencer_pkg::*;
#(
  parameter int                          DATA_W    = DATA_W_DEF,
  parameter int                          NUM_TAPS  = NUM_TAPS_DEF,
  parameter logic [NUM_TAPS*DATA_W-1:0]  COEF_INIT = COEF_INIT_DEF,
  parameter int                          ADDR_W    = tap_w(NUM_TAPS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              snap,
  input  logic              shift,
  output logic [DATA_W-1:0] q_head
);

  logic [DATA_W-1:0] bank_q  [NUM_TAPS];
  logic [DATA_W-1:0] bank_d  [NUM_TAPS];
  logic [DATA_W-1:0] shreg_q [NUM_TAPS];

  // Bank contents after this cycle's write; out-of-range addresses match no entry.
  always_comb begin
    bank_d = bank_q;
    for (int i = 0; i < NUM_TAPS; i++) begin
      if (wr_en && (addr == ADDR_W'(i))) bank_d[i] = wdata;
    end
  end

  // Bank storage, restored to the reset image whenever reset is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        bank_q[i] <= COEF_INIT[(NUM_TAPS-1-i)*DATA_W +: DATA_W];
      end
    end else begin
      bank_q <= bank_d;
    end
  end

  // Snapshot register: captured (write-through) at load start, shifted toward entry 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_TAPS; i++) shreg_q[i] <= '0;
    end else if (snap) begin
      shreg_q <= bank_d;
    end else if (shift) begin
      for (int i = 0; i < NUM_TAPS-1; i++) shreg_q[i] <= shreg_q[i+1];
      shreg_q[NUM_TAPS-1] <= '0;
    end
  end

  assign q_head = shreg_q[0];

endmodule

// File: rtl/fir_coeff_sequencer.sv
// Drive-side sequencer in front of the adaptive FIR. Streams samples to the
// FIR and, on request, pauses the stream to shift the coefficient bank out
// with s_set_coeffs high, followed by one GUARD cycle.
// Build option: SEQ_AUTOLOAD_EN -- when defined, a load of the reset
// coefficients is pending at reset, so the first cycles after reset release
// perform a load before streaming begins.
//
// Handshake: a sample transfers on a rising edge where smp_tvalid and
// smp_tready are both high; smp_tready is decoded from the registered state
// (high only in STREAM) and never depends on smp_tvalid. On the FIR side,
// s_axis_fir_tvalid and s_set_coeffs are registered and mutually exclusive.
module fir_coeff_sequencer
  import fir_coeff_sequencer_pkg::*;
#(
  parameter int                          DATA_W    = DATA_W_DEF,
  parameter int                          NUM_TAPS  = NUM_TAPS_DEF,
  parameter logic [NUM_TAPS*DATA_W-1:0]  COEF_INIT = COEF_INIT_DEF,
  localparam int                         ADDR_W    = tap_w(NUM_TAPS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_wr_en,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  input  logic              cfg_load_req,
  input  logic              smp_tvalid,
  input  logic [DATA_W-1:0] smp_tdata,
  output logic              smp_tready,
  output logic [DATA_W-1:0] x_n,
  output logic              s_axis_fir_tvalid,
  output logic              s_set_coeffs,
  output logic              busy,
  output logic              load_done,
  output seq_state_t        state_dbg
);

  localparam int                TAP_W    = ADDR_W;
  localparam logic [TAP_W-1:0]  LAST_TAP = TAP_W'(NUM_TAPS-1);

`ifdef SEQ_AUTOLOAD_EN
  localparam logic PENDING_RST = 1'b1;
`else
  localparam logic PENDING_RST = 1'b0;
`endif

  seq_state_t        state, next_state;
  logic [TAP_W-1:0]  tap, tap_nxt;
  logic              all_sent, all_sent_nxt;
  logic              pending, pending_nxt;
  logic              start_load;
  logic              shift;
  logic [DATA_W-1:0] q_head;
  logic [DATA_W-1:0] x_n_nxt;
  logic              tvalid_nxt, set_nxt, done_nxt;

  // A load starts from STREAM or GUARD on a fresh or pending request.
  assign start_load = (state != ST_LOAD) && (cfg_load_req || pending);
  assign smp_tready = (state == ST_STREAM);
  assign busy       = (state != ST_STREAM);
  assign state_dbg  = state;

  fir_coeff_bank #(
    .DATA_W    (DATA_W),
    .NUM_TAPS  (NUM_TAPS),
    .COEF_INIT (COEF_INIT),
    .ADDR_W    (ADDR_W)
  ) u_bank (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (cfg_wr_en),
    .addr   (cfg_addr),
    .wdata  (cfg_wdata),
    .snap   (start_load),
    .shift  (shift),
    .q_head (q_head)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_STREAM;
    else        state <= next_state;
  end

  // Next-state logic: LOAD lasts until every tap is out, then one GUARD cycle.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_STREAM: next_state = start_load ? ST_LOAD : ST_STREAM;
      ST_LOAD:   next_state = all_sent   ? ST_GUARD : ST_LOAD;
      ST_GUARD:  next_state = start_load ? ST_LOAD : ST_STREAM;
      default:   next_state = ST_STREAM;
    endcase
  end

  // Output and datapath next values: sample pass-through, coefficient shift-out, guard.
  always_comb begin
    x_n_nxt      = x_n;
    tvalid_nxt   = 1'b0;
    set_nxt      = 1'b0;
    done_nxt     = 1'b0;
    shift        = 1'b0;
    tap_nxt      = tap;
    all_sent_nxt = all_sent;
    // Requests merge into one pending load; starting a load consumes them.
    pending_nxt  = start_load ? 1'b0 : (pending | cfg_load_req);
    unique case (state)
      ST_STREAM: begin
        if (smp_tvalid) begin
          x_n_nxt    = smp_tdata;
          tvalid_nxt = 1'b1;
        end
        tap_nxt      = '0;
        all_sent_nxt = 1'b0;
      end
      ST_LOAD: begin
        if (!all_sent) begin
          x_n_nxt = q_head;
          set_nxt = 1'b1;
          shift   = 1'b1;
          if (tap == LAST_TAP) all_sent_nxt = 1'b1;
          else                 tap_nxt      = tap + TAP_W'(1);
        end else begin
          x_n_nxt  = '0;
          done_nxt = 1'b1;
        end
      end
      ST_GUARD: begin
        tap_nxt      = '0;
        all_sent_nxt = 1'b0;
      end
      default: begin
        tap_nxt      = '0;
        all_sent_nxt = 1'b0;
      end
    endcase
  end

  // Registered FIR-side outputs, tap counter and pending flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_n               <= '0;
      s_axis_fir_tvalid <= 1'b0;
      s_set_coeffs      <= 1'b0;
      load_done         <= 1'b0;
      tap               <= '0;
      all_sent          <= 1'b0;
      pending           <= PENDING_RST;
    end else begin
      x_n               <= x_n_nxt;
      s_axis_fir_tvalid <= tvalid_nxt;
      s_set_coeffs      <= set_nxt;
      load_done         <= done_nxt;
      tap               <= tap_nxt;
      all_sent          <= all_sent_nxt;
      pending           <= pending_nxt;
    end
  end

endmodule

// File: tb/tb_fir_coeff_sequencer.sv
// Directed bench for fir_coeff_sequencer: sample pass-through, coefficient
// loads, bank writes, merged requests and asynchronous reset mid-load.
module tb_fir_coeff_sequencer;
  import fir_coeff_sequencer_pkg::*;

  localparam int DATA_W = 6;
  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              cfg_wr_en;
  logic [ADDR_W-1:0] cfg_addr;
  logic [DATA_W-1:0] cfg_wdata;
  logic              cfg_load_req;
  logic              smp_tvalid;
  logic [DATA_W-1:0] smp_tdata;
  logic              smp_tready;
  logic [DATA_W-1:0] x_n;
  logic              s_axis_fir_tvalid;
  logic              s_set_coeffs;
  logic              busy;
  logic              load_done;
  seq_state_t        state_dbg;

  fir_coeff_sequencer dut (
    .clk               (clk),
    .reset             (reset),
    .cfg_wr_en         (cfg_wr_en),
    .cfg_addr          (cfg_addr),
    .cfg_wdata         (cfg_wdata),
    .cfg_load_req      (cfg_load_req),
    .smp_tvalid        (smp_tvalid),
    .smp_tdata         (smp_tdata),
    .smp_tready        (smp_tready),
    .x_n               (x_n),
    .s_axis_fir_tvalid (s_axis_fir_tvalid),
    .s_set_coeffs      (s_set_coeffs),
    .busy              (busy),
    .load_done         (load_done),
    .state_dbg         (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int n_checks  = 0;
  int n_pass    = 0;
  int n_done    = 0;
  int n_rdy_low = 0;
  int n_overlap = 0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic clear_obs();
    n_done    = 0;
    n_rdy_low = 0;
    n_overlap = 0;
    exp_q.delete();
  endtask

  // Per-cycle observation at the falling edge.
  task automatic observe();
    if (s_set_coeffs === 1'b1) begin
      if (exp_q.size() == 0) check("set_coeffs_unexpected", s_set_coeffs, 0);
      else check("coef", $signed(x_n), $signed(exp_q.pop_front()));
    end
    if (s_set_coeffs && s_axis_fir_tvalid) n_overlap++;
    if (load_done) n_done++;
    if (!smp_tready) n_rdy_low++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(negedge clk);
    observe();
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic write_coef(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    cfg_wr_en = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    cyc();
    cfg_wr_en = 1'b0;
  endtask

  task automatic push3(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                       input logic [DATA_W-1:0] c);
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(c);
  endtask

  task automatic end_of_load(input string tag, input int exp_done);
    check({tag, "_coefs_left"}, exp_q.size(), 0);
    check({tag, "_load_done"}, n_done, exp_done);
    check({tag, "_excl"}, n_overlap, 0);
  endtask

  // ---------------- stimulus ----------------
  logic [DATA_W-1:0] smp_vec [5] = '{6'd1, 6'd2, 6'd3, 6'h3F, 6'h20};
  logic [10:0]       req_pat     = 11'h01B;

  initial begin
    reset        = 1'b0;
    cfg_wr_en    = 1'b0;
    cfg_addr     = '0;
    cfg_wdata    = '0;
    cfg_load_req = 1'b0;
    smp_tvalid   = 1'b0;
    smp_tdata    = '0;

    repeat (2) @(negedge clk);
    check("rst_xn", x_n, 0);
    check("rst_tvalid", s_axis_fir_tvalid, 0);
    check("rst_set", s_set_coeffs, 0);
    check("rst_busy", busy, 0);
    check("rst_done", load_done, 0);
    check("rst_state", state_dbg, ST_STREAM);
    reset = 1'b1;

`ifdef SEQ_AUTOLOAD_EN
    // Autoload: one load of the reset image before streaming.
    clear_obs();
    push3(6'd7, 6'h3B, 6'd27);
    wait_cyc(6);
    end_of_load("t6", 1);
    check("t6_state", state_dbg, ST_STREAM);
`endif

    // Test 1: samples pass through with one cycle latency.
    for (int i = 0; i < 5; i++) begin
      smp_tvalid = 1'b1;
      smp_tdata  = smp_vec[i];
      cyc();
      check("t1_xn", $signed(x_n), $signed(smp_vec[i]));
      check("t1_tvalid", s_axis_fir_tvalid, 1);
      check("t1_set", s_set_coeffs, 0);
    end
    smp_tvalid = 1'b0;
    cyc();
    check("t1_idle_tvalid", s_axis_fir_tvalid, 0);
    check("t1_idle_hold", $signed(x_n), -32);

    // Test 2: default load; the sample accepted alongside the request still emits.
    clear_obs();
    push3(6'd7, 6'h3B, 6'd27);
    check("t2_ready_pre", smp_tready, 1);
    cfg_load_req = 1'b1;
    smp_tvalid   = 1'b1;
    smp_tdata    = 6'd5;
    cyc();
    cfg_load_req = 1'b0;
    smp_tdata    = 6'd6;
    check("t2_last_sample", $signed(x_n), 5);
    check("t2_last_tvalid", s_axis_fir_tvalid, 1);
    check("t2_busy", busy, 1);
    wait_cyc(5);
    end_of_load("t2", 1);
    check("t2_ready_low", n_rdy_low, 5);
    check("t2_busy_end", busy, 0);
    check("t2_guard_xn", $signed(x_n), 0);
    cyc();
    check("t2_held_sample", $signed(x_n), 6);
    check("t2_held_tvalid", s_axis_fir_tvalid, 1);
    smp_tvalid = 1'b0;
    cyc();

    // Test 4: extra requests during a load merge into one back-to-back load.
    clear_obs();
    push3(6'd7, 6'h3B, 6'd27);
    push3(6'd7, 6'h3B, 6'd27);
    for (int i = 0; i < 11; i++) begin
      cfg_load_req = req_pat[i];
      cyc();
    end
    cfg_load_req = 1'b0;
    end_of_load("t4", 2);
    check("t4_ready_low", n_rdy_low, 10);
    check("t4_state_end", state_dbg, ST_STREAM);

    // Test 3: bank writes, ignored address, snapshot isolation, write-through.
    write_coef(2'd1, 6'h20);
    write_coef(2'd3, 6'd9);
    clear_obs();
    push3(6'd7, 6'h20, 6'd27);
    cfg_load_req = 1'b1;
    cyc();
    cfg_load_req = 1'b0;
    cfg_wr_en    = 1'b1;
    cfg_addr     = 2'd0;
    cfg_wdata    = 6'd1;
    cyc();
    cfg_wr_en = 1'b0;
    wait_cyc(4);
    end_of_load("t3a", 1);
    clear_obs();
    push3(6'd1, 6'h20, 6'd3);
    cfg_load_req = 1'b1;
    cfg_wr_en    = 1'b1;
    cfg_addr     = 2'd2;
    cfg_wdata    = 6'd3;
    cyc();
    cfg_load_req = 1'b0;
    cfg_wr_en    = 1'b0;
    wait_cyc(5);
    end_of_load("t3b", 1);

    // Test 5: asynchronous reset during the second LOAD cycle.
    clear_obs();
    exp_q.push_back(6'd1);
    cfg_load_req = 1'b1;
    cyc();
    cfg_load_req = 1'b0;
    cyc();
    check("t5_mid_set", s_set_coeffs, 1);
    #2 reset = 1'b0;
    #1;
    check("t5_async_xn", x_n, 0);
    check("t5_async_set", s_set_coeffs, 0);
    check("t5_async_tvalid", s_axis_fir_tvalid, 0);
    check("t5_async_busy", busy, 0);
    check("t5_async_state", state_dbg, ST_STREAM);
    @(negedge clk);
    reset = 1'b1;
    cyc();
    check("t5_rel_state", state_dbg, ST_STREAM);
    check("t5_rel_ready", smp_tready, 1);
    check("t5_rel_set", s_set_coeffs, 0);
    clear_obs();
    push3(6'd7, 6'h3B, 6'd27);
    cfg_load_req = 1'b1;
    cyc();
    cfg_load_req = 1'b0;
    wait_cyc(5);
    end_of_load("t5", 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
